// File: rtl/mc_control_pkg.sv
// mc_control_pkg
//   Shared constants for the multi-cycle MIPS control unit: FSM state
//   encodings, opcode/funct values, ALU operation codes, datapath mux select
//   codes and small decode helpers.
package mc_control_pkg;

  // FSM state encodings
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_MEM_WR = 4'd6;
  localparam logic [3:0] S_WB_ALU = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_MULDIV = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Funct codes (IR[5:0]) that the control unit cares about
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b110;
  localparam logic [2:0] ALU_SLTU  = 3'b111;

  // Mux select codes
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_LUI    = 2'b10;
  localparam logic [1:0] WB_PC     = 2'b11;

  function automatic logic is_shift(input logic [5:0] fn);
    return (fn == F_SLL) || (fn == F_SRL) || (fn == F_SRA) ||
           (fn == F_SLLV) || (fn == F_SRLV) || (fn == F_SRAV);
  endfunction

  // Constant-amount shifts take their A operand from the shamt field
  function automatic logic is_shamt_shift(input logic [5:0] fn);
    return (fn == F_SLL) || (fn == F_SRL) || (fn == F_SRA);
  endfunction

  function automatic logic is_muldiv(input logic [5:0] fn);
    return (fn == F_MULT) || (fn == F_MULTU) || (fn == F_DIV) || (fn == F_DIVU);
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI:  return ALU_AND;
      OP_ORI:   return ALU_OR;
      OP_XORI:  return ALU_XOR;
      OP_SLTI:  return ALU_SLT;
      OP_SLTIU: return ALU_SLTU;
      default:  return ALU_ADD;
    endcase
  endfunction

  // Logical immediates and sltiu use a zero-extended immediate
  function automatic logic imm_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_SLTIU);
  endfunction

  // Counter width able to hold the larger of two terminal counts
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : int'($clog2(m + 1));
  endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// mc_wait_counter
//   Clear/enable counter with a terminal-count compare against a run-time
//   limit. Saturates at all-ones so a disabled limit can never wrap into a
//   false terminal count.
// Ports
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear (priority over en)
//   en         : count enable
//   limit      : terminal count value
//   count      : current count
//   tc         : count == limit
module mc_wait_counter #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)                   count <= '0;
    else if (clr)                 count <= '0;
    else if (en && (count != '1)) count <= count + WIDTH'(1);
  end

  assign tc = (count == limit);

endmodule

// File: rtl/mc_control.sv
// mc_control
//   Multi-cycle MIPS control unit. Sequences FETCH/DECODE/EXEC/MEM/WB for each
//   instruction, waits on the memory ready handshake with a timeout, runs an
//   iterative mult/div unit and traps on illegal opcodes.
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   opcode, funct       : IR fields (stable from DECODE onward)
//   zero                : ALU zero flag
//   mem_ready           : memory completes the access this cycle
//   mem_req/mem_we/iord : memory port control
//   ir_write/pc_write   : IR and PC load enables
//   pc_src, alu_src_a, alu_src_b, alu_op, shift, alu_src_shamt, ext_sign,
//   reg_dst, mem_to_reg : datapath mux selects and ALU control
//   reg_write           : register file write enable
//   muldiv_start        : one-cycle start pulse to the mult/div unit
//   hilo_write          : one-cycle HI/LO write pulse
//   instr_done          : pulse on the last cycle of each instruction
//   illegal, mem_fault  : sticky trap flags
module mc_control
  import mc_control_pkg::*;
#(
  parameter int unsigned ALUOP_W       = 3,
  parameter int unsigned HAS_MULDIV    = 1,
  parameter int unsigned MULDIV_CYCLES = 32,
  parameter int unsigned MEM_TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               shift,
  output logic               alu_src_shamt,
  output logic               ext_sign,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               muldiv_start,
  output logic               hilo_write,
  output logic               instr_done,
  output logic               illegal,
  output logic               mem_fault
);

  localparam int unsigned CNT_W = cnt_width(MULDIV_CYCLES, MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] MD_LAST  = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam logic TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic MD_LEGAL   = (HAS_MULDIV != 0);

  logic [3:0]       state, next_state;
  logic             in_access, in_muldiv, timeout;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt, cnt_limit;

  assign in_access = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign in_muldiv = (state == S_MULDIV);

  // One counter serves both uses: in an access it counts wait cycles, in
  // MULDIV it counts iterations. It is cleared in every other state, so it
  // always starts at zero on entry to either.
  assign cnt_clr   = !(in_access || in_muldiv) || (in_access && mem_ready);
  assign cnt_en    = in_muldiv || (in_access && !mem_ready);
  assign cnt_limit = in_muldiv ? MD_LAST : TO_LIMIT;

  // The count equals the number of wait cycles already spent; on the cycle
  // it reaches MEM_TIMEOUT a late mem_ready still completes the access.
  assign timeout = TIMEOUT_EN && in_access && !mem_ready && cnt_tc;

  mc_wait_counter #(.WIDTH(CNT_W)) u_wait_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (cnt_limit),
    .count (cnt),
    .tc    (cnt_tc)
  );

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)    next_state = S_DECODE;
        else if (timeout) next_state = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == F_JR)         next_state = S_JUMP;
            else if (is_muldiv(funct)) next_state = MD_LEGAL ? S_MULDIV : S_TRAP;
            else                       next_state = S_EXEC_R;
          end
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
          OP_SLTI, OP_SLTIU, OP_LUI:   next_state = S_EXEC_I;
          OP_LW, OP_SW:                next_state = S_ADDR;
          OP_BEQ, OP_BNE:              next_state = S_BRANCH;
          OP_J, OP_JAL:                next_state = S_JUMP;
          default:                     next_state = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: next_state = S_WB_ALU;
      S_ADDR:   next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)    next_state = S_WB_MEM;
        else if (timeout) next_state = S_TRAP;
      end
      S_MEM_WR: begin
        if (mem_ready)    next_state = S_FETCH;
        else if (timeout) next_state = S_TRAP;
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: next_state = S_FETCH;
      S_MULDIV: if (cnt_tc) next_state = S_FETCH;
      S_TRAP:   next_state = S_TRAP;
      default:  next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      illegal   <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == S_DECODE) && (next_state == S_TRAP)) illegal <= 1'b1;
      if (timeout) mem_fault <= 1'b1;
    end
  end

  // Output decode. Write enables for the register file, memory and HI/LO
  // depend only on the state register and the held IR fields; only IR/PC
  // loads, the branch PC write and the store-done pulse follow mem_ready/zero.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_RT;
    alu_op        = ALUOP_W'(ALU_ADD);
    shift         = 1'b0;
    alu_src_shamt = 1'b0;
    ext_sign      = 1'b0;
    reg_dst       = DST_RT;
    mem_to_reg    = WB_ALUOUT;
    reg_write     = 1'b0;
    muldiv_start  = 1'b0;
    hilo_write    = 1'b0;
    instr_done    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut
        alu_src_b = SRC_B_IMM_SH2;
      end
      S_EXEC_R: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_W'(ALU_FUNCT);
        shift         = is_shift(funct);
        alu_src_shamt = is_shamt_shift(funct);
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALUOP_W'(imm_alu_op(opcode));
        ext_sign  = imm_zero_ext(opcode);
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WR: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        mem_we     = 1'b1;
        instr_done = mem_ready;
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_RTYPE) ? DST_RD : DST_RT;
        mem_to_reg = (opcode == OP_LUI) ? WB_LUI : WB_ALUOUT;
        instr_done = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_MDR;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_W'(ALU_SUB);
        pc_src     = PC_SRC_ALUOUT;
        pc_write   = (opcode == OP_BNE) ? !zero : zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        instr_done = 1'b1;
        if (opcode == OP_RTYPE) begin
          pc_src = PC_SRC_RS;
        end else begin
          pc_src = PC_SRC_JUMP;
          if (opcode == OP_JAL) begin
            // PC already holds PC+4 from FETCH
            reg_write  = 1'b1;
            reg_dst    = DST_RA;
            mem_to_reg = WB_PC;
          end
        end
      end
      S_MULDIV: begin
        muldiv_start = (cnt == '0);
        hilo_write   = cnt_tc;
        instr_done   = cnt_tc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control
//   Self-checking bench for mc_control: a table of whole-instruction vectors
//   (latency and control word on the instr_done cycle) plus hand-written
//   sequences for wait states, timeout, traps and reset during MULDIV.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_a;
  logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic [2:0] alu_op;
  logic       shift, alu_src_shamt, ext_sign, reg_write;
  logic       muldiv_start, hilo_write, instr_done, illegal, mem_fault;

  // Second instance built without the mult/div unit
  logic       nm_mem_req, nm_mem_we, nm_iord, nm_ir_write, nm_pc_write, nm_alu_src_a;
  logic [1:0] nm_pc_src, nm_alu_src_b, nm_reg_dst, nm_mem_to_reg;
  logic [2:0] nm_alu_op;
  logic       nm_shift, nm_alu_src_shamt, nm_ext_sign, nm_reg_write;
  logic       nm_muldiv_start, nm_hilo_write, nm_instr_done, nm_illegal, nm_mem_fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_control #(.ALUOP_W(3), .HAS_MULDIV(1), .MULDIV_CYCLES(32), .MEM_TIMEOUT(15)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .shift(shift), .alu_src_shamt(alu_src_shamt),
    .ext_sign(ext_sign), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .muldiv_start(muldiv_start), .hilo_write(hilo_write), .instr_done(instr_done),
    .illegal(illegal), .mem_fault(mem_fault)
  );

  mc_control #(.ALUOP_W(3), .HAS_MULDIV(0), .MULDIV_CYCLES(4), .MEM_TIMEOUT(15)) u_dut_nomd (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(nm_mem_req), .mem_we(nm_mem_we), .iord(nm_iord),
    .ir_write(nm_ir_write), .pc_write(nm_pc_write), .pc_src(nm_pc_src),
    .alu_src_a(nm_alu_src_a), .alu_src_b(nm_alu_src_b), .alu_op(nm_alu_op),
    .shift(nm_shift), .alu_src_shamt(nm_alu_src_shamt), .ext_sign(nm_ext_sign),
    .reg_dst(nm_reg_dst), .mem_to_reg(nm_mem_to_reg), .reg_write(nm_reg_write),
    .muldiv_start(nm_muldiv_start), .hilo_write(nm_hilo_write),
    .instr_done(nm_instr_done), .illegal(nm_illegal), .mem_fault(nm_mem_fault)
  );

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         lat;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // {pc_write, pc_src, reg_write, reg_dst, mem_to_reg, mem_we, hilo_write, mem_req, iord}
  function automatic logic [11:0] mk(input logic pcw, input logic [1:0] pcs, input logic rw,
                                     input logic [1:0] rd, input logic [1:0] m2r,
                                     input logic we, input logic hw, input logic req,
                                     input logic io);
    return {pcw, pcs, rw, rd, m2r, we, hw, req, io};
  endfunction

  function automatic logic [11:0] bundle();
    return {pc_write, pc_src, reg_write, reg_dst, mem_to_reg, mem_we, hilo_write, mem_req, iord};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs an I-type instruction to its EXEC_I cycle (cycle 3) and checks ALU controls
  task automatic ichk(input string name, input logic [5:0] op, input logic ext, input logic [2:0] aop);
    do_reset();
    opcode = op; funct = 6'h00; mem_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) check(name, {ext_sign, alu_op, alu_src_a, alu_src_b}, {ext, aop, 1'b1, 2'b10});
      next_cycle();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        got;
    int          lat, cnt_a, cnt_b, done_cyc;
    logic [11:0] act;

    vecs.push_back('{"add",      6'h00, 6'h20, 1'b0, 4,  mk(0, 2'b00, 1, 2'b01, 2'b00, 0, 0, 0, 0)});
    vecs.push_back('{"sll",      6'h00, 6'h00, 1'b0, 4,  mk(0, 2'b00, 1, 2'b01, 2'b00, 0, 0, 0, 0)});
    vecs.push_back('{"addi",     6'h08, 6'h00, 1'b0, 4,  mk(0, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 0)});
    vecs.push_back('{"ori",      6'h0D, 6'h00, 1'b0, 4,  mk(0, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 0)});
    vecs.push_back('{"lui",      6'h0F, 6'h00, 1'b0, 4,  mk(0, 2'b00, 1, 2'b00, 2'b10, 0, 0, 0, 0)});
    vecs.push_back('{"lw",       6'h23, 6'h00, 1'b0, 5,  mk(0, 2'b00, 1, 2'b00, 2'b01, 0, 0, 0, 0)});
    vecs.push_back('{"sw",       6'h2B, 6'h00, 1'b0, 4,  mk(0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1, 1)});
    vecs.push_back('{"beq_z1",   6'h04, 6'h00, 1'b1, 3,  mk(1, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0, 0)});
    vecs.push_back('{"beq_z0",   6'h04, 6'h00, 1'b0, 3,  mk(0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0, 0)});
    vecs.push_back('{"bne_z0",   6'h05, 6'h00, 1'b0, 3,  mk(1, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0, 0)});
    vecs.push_back('{"bne_z1",   6'h05, 6'h00, 1'b1, 3,  mk(0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0, 0)});
    vecs.push_back('{"j",        6'h02, 6'h00, 1'b0, 3,  mk(1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0, 0)});
    vecs.push_back('{"jal",      6'h03, 6'h00, 1'b0, 3,  mk(1, 2'b10, 1, 2'b10, 2'b11, 0, 0, 0, 0)});
    vecs.push_back('{"jr",       6'h00, 6'h08, 1'b0, 3,  mk(1, 2'b11, 0, 2'b00, 2'b00, 0, 0, 0, 0)});
    vecs.push_back('{"mult",     6'h00, 6'h18, 1'b0, 34, mk(0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 0, 0)});
    vecs.push_back('{"divu",     6'h00, 6'h1B, 1'b0, 34, mk(0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 0, 0)});

    // Reset state: FETCH, nothing written, flags clear
    do_reset();
    @(negedge clk);
    check("reset_ctrl", bundle(), mk(0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1, 0));
    check("reset_flags", {illegal, mem_fault, ir_write, instr_done, muldiv_start}, 5'b00000);
    next_cycle();

    // Whole-instruction table, memory always ready
    foreach (vecs[v]) begin
      do_reset();
      opcode = vecs[v].op; funct = vecs[v].fn; zero = vecs[v].z; mem_ready = 1'b1;
      got = 1'b0; lat = 0; act = '0;
      for (int c = 1; c <= 64 && !got; c++) begin
        @(negedge clk);
        if (instr_done) begin
          got = 1'b1; lat = c; act = bundle();
        end
        next_cycle();
      end
      check({vecs[v].name, "_latency"}, lat, vecs[v].lat);
      check({vecs[v].name, "_final"}, act, vecs[v].exp);
    end
    zero = 1'b0;

    // add: FETCH loads IR/PC, EXEC_R selects rs/rt with funct ALU op
    do_reset();
    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) check("add_fetch", {ir_write, pc_write, alu_src_b, alu_op}, {1'b1, 1'b1, 2'b01, 3'b000});
      if (c == 2) check("add_decode", {alu_src_a, alu_src_b, alu_op, ir_write}, {1'b0, 2'b11, 3'b000, 1'b0});
      if (c == 3) check("add_exec", {alu_src_a, alu_src_b, alu_op, shift}, {1'b1, 2'b00, 3'b010, 1'b0});
      next_cycle();
    end

    // srl: constant shift uses shamt path
    do_reset();
    opcode = 6'h00; funct = 6'h02; mem_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) check("srl_exec", {shift, alu_src_shamt}, 2'b11);
      next_cycle();
    end

    ichk("andi_exec",  6'h0C, 1'b1, 3'b011);
    ichk("addi_exec",  6'h08, 1'b0, 3'b000);
    ichk("sltiu_exec", 6'h0B, 1'b1, 3'b111);
    ichk("slti_exec",  6'h0A, 1'b0, 3'b110);

    // lw with three wait states in MEM_RD; mem_ready high while idle is ignored
    do_reset();
    opcode = 6'h23; funct = 6'h00;
    cnt_a = 0; done_cyc = 0; act = '0;
    for (int c = 1; c <= 9; c++) begin
      mem_ready = !(c == 4 || c == 5 || c == 6);
      @(negedge clk);
      if (mem_req && iord) cnt_a++;
      if (instr_done && done_cyc == 0) begin
        done_cyc = c; act = bundle();
      end
      next_cycle();
    end
    check("lw_wait_rd_cycles", cnt_a, 4);
    check("lw_wait_done_cycle", done_cyc, 8);
    check("lw_wait_wb", act, mk(0, 2'b00, 1, 2'b00, 2'b01, 0, 0, 0, 0));

    // Illegal opcode: trap, sticky until reset
    do_reset();
    opcode = 6'h3F; funct = 6'h00; mem_ready = 1'b1;
    cnt_a = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (instr_done) cnt_a++;
      if (c == 2) check("illegal_decode", illegal, 1'b0);
      if (c == 8) check("illegal_trap", {illegal, mem_fault, mem_req, ir_write, pc_write, reg_write}, 6'b100000);
      next_cycle();
    end
    check("illegal_no_done", cnt_a, 0);
    do_reset();
    @(negedge clk);
    check("illegal_cleared", {illegal, mem_req}, 2'b01);
    next_cycle();

    // mult: legal with the unit, traps without it
    do_reset();
    opcode = 6'h00; funct = 6'h18; mem_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 3) check("mult_start", muldiv_start, 1'b1);
      if (c == 4) begin
        check("mult_legal", {illegal, muldiv_start}, 2'b00);
        check("nomd_mult_trap", {nm_illegal, nm_mem_req, nm_muldiv_start}, 3'b100);
      end
      next_cycle();
    end

    // Timeout in FETCH: 15 wait cycles tolerated, 16th without ready traps
    do_reset();
    mem_ready = 1'b0; opcode = 6'h00; funct = 6'h20;
    for (int c = 1; c <= 20; c++) begin
      if (c > 17) mem_ready = 1'b1;
      @(negedge clk);
      if (c == 16) check("timeout_last_wait", {mem_fault, mem_req}, 2'b01);
      if (c == 17) check("timeout_trap", {mem_fault, mem_req}, 2'b10);
      if (c == 20) check("timeout_held", {mem_fault, mem_req, ir_write}, 3'b100);
      next_cycle();
    end

    // mem_ready arriving on the timeout cycle completes the fetch
    do_reset();
    for (int c = 1; c <= 17; c++) begin
      mem_ready = (c == 16);
      @(negedge clk);
      if (c == 16) check("timeout_ready_wins_fetch", {ir_write, pc_write, mem_fault}, 3'b110);
      if (c == 17) check("timeout_ready_wins_decode", {mem_fault, mem_req, alu_src_b}, {1'b0, 1'b0, 2'b11});
      next_cycle();
    end

    // Reset mid-MULDIV: back to FETCH, no HI/LO write
    do_reset();
    opcode = 6'h00; funct = 6'h1A; mem_ready = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (muldiv_start) cnt_b++;
      if (hilo_write) cnt_a++;
      next_cycle();
    end
    check("div_start_once", cnt_b, 1);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (hilo_write) cnt_a++;
      if (c == 1) check("div_reset_fetch", {mem_req, iord, muldiv_start}, 3'b100);
      next_cycle();
    end
    check("div_reset_no_hilo", cnt_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
